// File: rtl/wam_hit_pkg.sv
// -----------------------------------------------------------------------------
// wam_pkg -- shared types and helpers for the whack-a-mole hit judge.
//   NCH          : number of holes / button channels
//   ch_mask_t    : one bit per channel (buttons, moles, hits, pending queue)
//   emit_state_t : states of the hit-pulse emitter
//   lowest_bit   : isolates the lowest set bit of a mask (one-hot or zero)
//   popcount     : number of set bits in a mask
// -----------------------------------------------------------------------------
package wam_pkg;

    localparam int NCH = 8;

    typedef logic [NCH-1:0] ch_mask_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } emit_state_t;

    // Two's-complement trick: m & -m keeps only the least significant one.
    function automatic ch_mask_t lowest_bit(input ch_mask_t m);
        return m & (~m + ch_mask_t'(1));
    endfunction

    function automatic logic [3:0] popcount(input ch_mask_t m);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NCH; i++) begin
            n = n + {3'b000, m[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/wam_hit_if.sv
// -----------------------------------------------------------------------------
// wam_hit_if -- player/mole side bundle of the hit judge.
//   btn      : raw, asynchronous, bouncing buttons (one per hole)
//   mole     : mole-up mask, synchronous to clk
//   hit      : one-hot hit pulse towards the score counter
//   whack    : one-cycle request to drop mole i
//   busy     : emitter active or hits pending
//   miss     : one-cycle miss pulse           (only with WAM_MISS_EN)
//   miss_cnt : saturating miss counter        (only with WAM_MISS_EN)
// Modports: master = environment (drives btn/mole), slave = wam_hit.
// -----------------------------------------------------------------------------
interface wam_hit_if;
    import wam_pkg::*;

    ch_mask_t   btn;
    ch_mask_t   mole;
    ch_mask_t   hit;
    ch_mask_t   whack;
    logic       busy;
`ifdef WAM_MISS_EN
    logic       miss;
    logic [7:0] miss_cnt;

    modport master (output btn, mole, input hit, whack, busy, miss, miss_cnt);
    modport slave  (input btn, mole, output hit, whack, busy, miss, miss_cnt);
`else
    modport master (output btn, mole, input hit, whack, busy);
    modport slave  (input btn, mole, output hit, whack, busy);
`endif

endinterface

// File: rtl/wam_hit_dbc.sv
// -----------------------------------------------------------------------------
// wam_dbc -- single-channel two-flop synchroniser plus debouncer.
//   clk  : system clock
//   clr  : asynchronous, active-high reset
//   btn  : raw asynchronous button level
//   rise : one-cycle pulse, registered together with a 0->1 change of the
//          debounced state
// The debounced state changes only after DB_CYC consecutive synchronised
// samples that differ from it; any agreeing sample restarts the count.
// -----------------------------------------------------------------------------
module wam_dbc #(
    parameter int DB_CYC = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic rise
);

    localparam int CW = $clog2(DB_CYC + 1);

    logic [1:0]    sync;
    logic          db;
    logic [CW-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync <= '0;
            db   <= 1'b0;
            cnt  <= '0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            rise <= 1'b0;
            if (sync[1] == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYC - 1)) begin
                // DB_CYC-th consecutive differing sample: accept the new level.
                cnt  <= '0;
                db   <= sync[1];
                rise <= sync[1];
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/wam_hit.sv
// -----------------------------------------------------------------------------
// wam_hit -- hit judge for the whack-a-mole game.
//   clk : system clock
//   clr : asynchronous, active-high reset (also drops hit immediately)
//   bus : wam_hit_if.slave (btn, mole in; hit, whack, busy, [miss, miss_cnt] out)
// Parameters:
//   DB_CYC  : stable samples needed to change a debounced button state
//   PULSE_W : cycles each hit pulse is held high
//   GAP_W   : minimum all-zero cycles between hit pulses
// Optional feature macro: WAM_MISS_EN adds the miss pulse and the saturating
// miss counter; without it misses are silently dropped.
//
// Each debounced press that finds its mole up and no hit already queued on
// that hole sets a pending bit and whacks the mole. The emitter drains the
// pending bits lowest index first as spaced one-hot pulses, so an edge-counting
// score counter sees every hit separately.
// -----------------------------------------------------------------------------
module wam_hit
    import wam_pkg::*;
#(
    parameter int DB_CYC  = 16,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2
) (
    input  logic      clk,
    input  logic      clr,
    wam_hit_if.slave  bus
);

    localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    ch_mask_t      rise;
    ch_mask_t      pend;
    ch_mask_t      sel;
    ch_mask_t      pend_kept;
    ch_mask_t      set_mask;
    ch_mask_t      whack_q;
    ch_mask_t      hit_q;
    emit_state_t   state;
    logic [CW-1:0] cnt;

    // ---------------------------------------------------------------- inputs
    for (genvar i = 0; i < NCH; i++) begin : g_dbc
        wam_dbc #(.DB_CYC(DB_CYC)) u_dbc (
            .clk  (clk),
            .clr  (clr),
            .btn  (bus.btn[i]),
            .rise (rise[i])
        );
    end

    // ------------------------------------------------------------ judgement
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        sel = '0;
        if (state == IDLE) begin
            sel = lowest_bit(pend);
        end
    end

    // A bit being drained this cycle already counts as free, so a press that
    // lands on it re-queues the hit (set wins over the selection clear).
    assign pend_kept = pend & ~sel;
    assign set_mask  = rise & bus.mole & ~pend_kept;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pend    <= '0;
            whack_q <= '0;
        end else begin
            pend    <= pend_kept | set_mask;
            whack_q <= set_mask;
        end
    end

    // -------------------------------------------------------------- emitter
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
            hit_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pend != '0) begin
                        hit_q <= sel;
                        cnt   <= CW'(PULSE_W - 1);
                        state <= PULSE;
                    end else begin
                        hit_q <= '0;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        hit_q <= '0;
                        cnt   <= CW'(GAP_W - 1);
                        state <= GAP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    hit_q <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.hit   = hit_q;
    assign bus.whack = whack_q;
    assign bus.busy  = (state != IDLE) || (pend != '0);

    // ------------------------------------------------------------ miss path
`ifdef WAM_MISS_EN
    ch_mask_t   miss_vec;
    logic [8:0] miss_sum;
    logic       miss_q;
    logic [7:0] miss_cnt_q;

    assign miss_vec = rise & ~bus.mole;
    // One spare bit catches overflow so the counter can clamp at 255.
    assign miss_sum = {1'b0, miss_cnt_q} + {5'b00000, popcount(miss_vec)};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            miss_q     <= 1'b0;
            miss_cnt_q <= '0;
        end else begin
            miss_q     <= |miss_vec;
            miss_cnt_q <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
        end
    end

    assign bus.miss     = miss_q;
    assign bus.miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_wam_hit.sv
// -----------------------------------------------------------------------------
// tb_wam_hit -- directed self-checking bench for wam_hit with DB_CYC=4,
// PULSE_W=2, GAP_W=2. Inputs change right after a falling edge; outputs are
// sampled on falling edges into per-cycle traces, index 0 being the sample
// after the first rising edge that sees the new inputs. With these parameters
// a clean press shows whack at index 6 and hit at indices 7..8.
// Define WAM_MISS_EN to also exercise the miss outputs.
// -----------------------------------------------------------------------------
module tb_wam_hit;
    import wam_pkg::*;

    localparam int TR_LEN = 256;

    logic clk = 1'b0;
    logic clr = 1'b1;

    wam_hit_if ifc ();

    wam_hit #(
        .DB_CYC  (4),
        .PULSE_W (2),
        .GAP_W   (2)
    ) dut (
        .clk (clk),
        .clr (clr),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int viol     = 0;

    logic [7:0] hit_tr   [TR_LEN];
    logic [7:0] whack_tr [TR_LEN];
    logic [7:0] miss_tr  [TR_LEN];
    logic       busy_tr  [TR_LEN];
    int         tr_n;
    logic [7:0] prev_hit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_tr();
        tr_n = 0;
        for (int i = 0; i < TR_LEN; i++) begin
            hit_tr[i]   = '0;
            whack_tr[i] = '0;
            miss_tr[i]  = '0;
            busy_tr[i]  = 1'b0;
        end
    endtask

    // Advance n cycles, recording outputs and checking the hit invariants.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if ((ifc.hit & (ifc.hit - 8'd1)) != 8'd0) viol++;
            if (prev_hit != 8'd0 && ifc.hit != 8'd0 && ifc.hit != prev_hit) viol++;
            prev_hit = ifc.hit;
            if (tr_n < TR_LEN) begin
                hit_tr[tr_n]   = ifc.hit;
                whack_tr[tr_n] = ifc.whack;
                busy_tr[tr_n]  = ifc.busy;
`ifdef WAM_MISS_EN
                miss_tr[tr_n]  = {7'd0, ifc.miss};
`endif
                tr_n++;
            end
        end
    endtask

    function automatic logic [7:0] tr_at(input int w, input int i);
        case (w)
            0:       return hit_tr[i];
            1:       return whack_tr[i];
            default: return miss_tr[i];
        endcase
    endfunction

    function automatic int nz_cycles(input int w);
        int n = 0;
        for (int i = 0; i < tr_n; i++) if (tr_at(w, i) != 8'd0) n++;
        return n;
    endfunction

    function automatic int pulses(input int w);
        int n = 0;
        for (int i = 0; i < tr_n; i++)
            if (tr_at(w, i) != 8'd0 && (i == 0 || tr_at(w, i - 1) == 8'd0)) n++;
        return n;
    endfunction

    function automatic int first_nz(input int w);
        for (int i = 0; i < tr_n; i++) if (tr_at(w, i) != 8'd0) return i;
        return -1;
    endfunction

    bit found;

    initial begin
        ifc.btn  = '0;
        ifc.mole = '0;
        prev_hit = '0;
        clear_tr();

        // ---------------------------------------------------------- reset
        #1;
        check("rst_hit",   ifc.hit,   8'h00);
        check("rst_whack", ifc.whack, 8'h00);
        check("rst_busy",  ifc.busy,  1'b0);
`ifdef WAM_MISS_EN
        check("rst_miss",     ifc.miss,     1'b0);
        check("rst_miss_cnt", ifc.miss_cnt, 8'h00);
`endif
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        run(4);

        // ----------------------------------------------------- single hit
        clear_tr();
        ifc.mole = 8'h04;
        ifc.btn  = 8'h04;
        run(20);
        ifc.btn = 8'h00;
        run(20);
        check("single_whack_idx",    first_nz(1),  6);
        check("single_whack_val",    whack_tr[6],  8'h04);
        check("single_whack_cycles", nz_cycles(1), 1);
        check("single_hit_idx",      first_nz(0),  7);
        check("single_hit_val0",     hit_tr[7],    8'h04);
        check("single_hit_val1",     hit_tr[8],    8'h04);
        check("single_hit_cycles",   nz_cycles(0), 2);
        check("single_hit_pulses",   pulses(0),    1);
        check("single_busy_end",     busy_tr[tr_n - 1], 1'b0);

        // ------------------------------------------------ bounce rejection
        clear_tr();
        ifc.mole = 8'h02;
        for (int k = 0; k < 15; k++) begin
            ifc.btn = (k % 2 == 0) ? 8'h02 : 8'h00;
            run(2);
        end
        ifc.btn = 8'h00;
        run(10);
        check("bounce_hit",   nz_cycles(0), 0);
        check("bounce_whack", nz_cycles(1), 0);

        // --------------------------------------------- simultaneous press
        clear_tr();
        ifc.mole = 8'h21;
        ifc.btn  = 8'h21;
        run(30);
        ifc.btn = 8'h00;
        run(12);
        check("sim_whack_val", whack_tr[6], 8'h21);
        check("sim_hit7",  hit_tr[7],  8'h01);
        check("sim_hit8",  hit_tr[8],  8'h01);
        check("sim_hit9",  hit_tr[9],  8'h00);
        check("sim_hit10", hit_tr[10], 8'h00);
        check("sim_hit11", hit_tr[11], 8'h00);
        check("sim_hit12", hit_tr[12], 8'h20);
        check("sim_hit13", hit_tr[13], 8'h20);
        check("sim_hit14", hit_tr[14], 8'h00);
        check("sim_busy15", busy_tr[15], 1'b1);
        check("sim_busy16", busy_tr[16], 1'b0);
        check("sim_pulses", pulses(0), 2);

        // ------------------------------------------------------------ miss
        clear_tr();
        ifc.mole = 8'h00;
        ifc.btn  = 8'h08;
        run(20);
        ifc.btn = 8'h00;
        run(12);
        check("miss_no_hit",   nz_cycles(0), 0);
        check("miss_no_whack", nz_cycles(1), 0);
`ifdef WAM_MISS_EN
        check("miss_idx",    first_nz(2), 6);
        check("miss_pulses", pulses(2),   1);
        check("miss_cnt1",   ifc.miss_cnt, 8'd1);
        for (int r = 0; r < 38; r++) begin
            clear_tr();
            ifc.btn = 8'hFF;
            run(12);
            ifc.btn = 8'h00;
            run(12);
            if (r == 0)  check("miss_cnt_9",   ifc.miss_cnt, 8'd9);
            if (r == 30) check("miss_cnt_249", ifc.miss_cnt, 8'd249);
        end
        check("miss_cnt_sat", ifc.miss_cnt, 8'd255);
        check("miss_sat_no_hit", nz_cycles(0), 0);
`endif

        // -------------------------------------------- hold and re-press
        clear_tr();
        ifc.mole = 8'h40;
        ifc.btn  = 8'h40;
        run(100);
        check("hold_pulses", pulses(0), 1);
        check("hold_whacks", pulses(1), 1);
        ifc.btn = 8'h00;
        run(10);
        ifc.btn = 8'h40;
        run(20);
        ifc.btn = 8'h00;
        run(10);
        check("repress_pulses", pulses(0), 2);
        check("repress_whacks", pulses(1), 2);

        // -------------------------------------------- reset mid-operation
        ifc.mole = 8'hC0;
        ifc.btn  = 8'hC0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (ifc.hit == 8'h40) found = 1'b1;
        end
        check("rst_mid_reached", found, 1'b1);
        check("rst_mid_busy_pre", ifc.busy, 1'b1);
        #2;
        clr = 1'b1;
        #1;
        check("rst_mid_hit",  ifc.hit,  8'h00);
        check("rst_mid_busy", ifc.busy, 1'b0);
        ifc.btn  = 8'h00;
        ifc.mole = 8'h00;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        clear_tr();
        prev_hit = '0;
        run(30);
        check("rst_after_hit",   nz_cycles(0), 0);
        check("rst_after_whack", nz_cycles(1), 0);
        check("rst_after_busy",  busy_tr[tr_n - 1], 1'b0);

        check("invariants", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
